// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: fetch FSM state encodings,
// the misaligned-fetch exception cause and the sequential fetch step.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fq_state_t;

  localparam int unsigned EX_MISALIGNED_FETCH = 1;
  localparam int unsigned INSTR_STEP          = 4;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Fetch queue storage: DEPTH-entry FIFO with wrapping pointers, fill level
// and a synchronous clear that may be combined with a push of a first entry.
module fq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [LW-1:0]    o_level,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [AW-1:0]    w_waddr;

  // A clear restarts the write pointer at slot 0, so a push alongside it lands there.
  assign w_waddr = i_clr ? '0 : r_wptr;

  // Pointer and level update; clear discards any pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_rptr  <= '0;
      r_wptr  <= i_push ? AW'(1) : '0;
      r_level <= i_push ? LW'(1) : '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end

  // Entry storage, written on push.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch queue between the IMem port and decode. Keeps at most one
// IMem request outstanding, buffers responses in fq_fifo and redirects on flush.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue response bypass).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       EX_W     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      imem_rd_addr,
  output logic                   imem_rd_enable,
  input  logic [INSTR_W-1:0]     imem_rd_data,
  input  logic                   imem_rd_ready,
  output logic [INSTR_W-1:0]     instr,
  output logic [ADDR_W-1:0]      PC,
  output logic                   pipeline_valid,
  output logic [EX_W-1:0]        exception,
  output logic                   exception_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_addr,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + INSTR_W + EX_W + 1;

  fq_state_t          r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt, r_req_addr;
  logic               r_run;
  logic [EW-1:0]      w_push_data, w_head;
  logic [LW-1:0]      w_level;
  logic               w_empty, w_pop, w_fifo_pop, w_fifo_push;
  logic               w_resp, w_misalign, w_room, w_req_idle, w_outstanding, w_bypass;
  logic [ADDR_W-1:0]  w_head_pc;
  logic [INSTR_W-1:0] w_head_instr;
  logic [EX_W-1:0]    w_head_ex;
  logic               w_head_exv;

  assign {w_head_pc, w_head_instr, w_head_ex, w_head_exv} = w_head;

  assign w_resp        = (r_state == ST_WAIT) && imem_rd_ready && !flush;
  assign w_misalign    = flush && is_misaligned(flush_addr[1:0]);
  assign w_pop         = pipeline_valid && !stall && !flush;
  assign w_room        = (w_level < LW'(DEPTH)) || w_pop;
  assign w_req_idle    = (r_state == ST_IDLE) && r_run && w_room && !flush;
  assign w_outstanding = ((r_state == ST_WAIT) || (r_state == ST_DRAIN)) && !imem_rd_ready;
  assign w_fifo_pop    = w_pop && !w_empty;

  assign w_push_data = w_misalign
    ? {flush_addr, {INSTR_W{1'b0}}, EX_W'(EX_MISALIGNED_FETCH), 1'b1}
    : {r_pc, imem_rd_data, {EX_W{1'b0}}, 1'b0};

`ifdef FETCH_QUEUE_BYPASS_EN
  // A response arriving at an empty queue is shown directly; it is stored only if decode stalls.
  assign w_bypass    = w_resp && w_empty;
  assign w_fifo_push = w_misalign || (w_resp && (!w_bypass || stall));
`else
  assign w_bypass    = 1'b0;
  assign w_fifo_push = w_misalign || w_resp;
`endif

  // The request stays high through DRAIN with the original address so the IMem handshake completes.
  assign imem_rd_enable = w_req_idle || (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign imem_rd_addr   = ((r_state == ST_WAIT) || (r_state == ST_DRAIN)) ? r_req_addr : r_pc;
  assign fill_level     = w_level;

  fq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (flush),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_wdata (w_push_data),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_empty (w_empty)
  );

  // Head presentation; fields read as zero whenever nothing valid is shown.
  always_comb begin
    pipeline_valid  = !w_empty;
    instr           = w_head_instr;
    PC              = w_head_pc;
    exception       = w_head_ex;
    exception_valid = w_head_exv;
    if (w_bypass) begin
      pipeline_valid  = 1'b1;
      instr           = imem_rd_data;
      PC              = r_pc;
      exception       = '0;
      exception_valid = 1'b0;
    end
    if (!pipeline_valid) begin
      instr           = '0;
      PC              = '0;
      exception       = '0;
      exception_valid = 1'b0;
    end
  end

  // Fetch FSM next state and fetch PC; flush takes priority over every other event.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (flush) begin
      w_pc_nxt = flush_addr;
      if (w_misalign)         w_state_nxt = ST_HALT;
      else if (w_outstanding) w_state_nxt = ST_DRAIN;
      else                    w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (w_req_idle) w_state_nxt = ST_WAIT;
        ST_WAIT:  if (imem_rd_ready) begin
                    w_pc_nxt    = r_pc + ADDR_W'(INSTR_STEP);
                    w_state_nxt = ST_IDLE;
                  end
        ST_DRAIN: if (imem_rd_ready) w_state_nxt = ST_IDLE;
        ST_HALT:  w_state_nxt = ST_HALT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, fetch PC, issued request address and post-reset run enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_run      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_run   <= 1'b1;
      if (w_req_idle) r_req_addr <= r_pc;
    end
  end

endmodule
